// File: rtl/opera_bus_decoder.sv
// Wishbone address decoder / response mux: base/mask region decode, one registered access in flight.
// Optional bus-timeout error is enabled by defining BUS_TIMEOUT_EN.
module opera_bus_decoder #(
  parameter int unsigned              NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLV_BASE       = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0] SLV_MASK       = {NUM_SLAVES{32'hFFFF0000}},
  parameter int unsigned              TIMEOUT_CYCLES = 255
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic [31:0]                  i_wb_adr,
  input  logic [31:0]                  i_wb_dat,
  input  logic [3:0]                   i_wb_sel,
  input  logic                         i_wb_we,
  input  logic                         i_wb_cyc,
  input  logic                         i_wb_stb,
  output logic [31:0]                  o_wb_dat,
  output logic                         o_wb_ack,
  output logic                         o_wb_err,
  output logic [31:0]                  o_s_adr,
  output logic [31:0]                  o_s_dat,
  output logic [3:0]                   o_s_sel,
  output logic                         o_s_we,
  output logic [NUM_SLAVES:0]          o_s_stb,
  input  logic [32*(NUM_SLAVES+1)-1:0] i_s_dat,
  input  logic [NUM_SLAVES:0]          i_s_ack
);

  localparam int unsigned NS = NUM_SLAVES + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e          state_q, state_d;
  logic [31:0]     adr_q, adr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [3:0]      sel_q, sel_d;
  logic            we_q, we_d, ack_q, ack_d;
  logic [NS-1:0]   stb_q, stb_d;
  logic [NS-1:0]   dec_c;
  logic            hit_c, slv_ack_c;
  logic [31:0]     slv_dat_c;

`ifdef BUS_TIMEOUT_EN
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // Region decode: lowest matching index wins, no match selects the default port
  always_comb begin
    dec_c = '0;
    hit_c = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (!hit_c && ((i_wb_adr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
        dec_c[i] = 1'b1;
        hit_c    = 1'b1;
      end
    end
    if (!hit_c) dec_c[NUM_SLAVES] = 1'b1;
  end

  // Only the strobed slave's ack and data are visible to the FSM
  always_comb begin
    slv_ack_c = |(i_s_ack & stb_q);
    slv_dat_c = '0;
    for (int i = 0; i < int'(NS); i++) begin
      if (stb_q[i]) slv_dat_c = slv_dat_c | i_s_dat[32*i +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          adr_d   = i_wb_adr;
          wdat_d  = i_wb_dat;
          sel_d   = i_wb_sel;
          we_d    = i_wb_we;
          stb_d   = dec_c;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Master abort beats a same-cycle slave ack
        if (!i_wb_cyc) begin
          stb_d   = '0;
          state_d = IDLE;
        end else if (slv_ack_c) begin
          rdat_d  = slv_dat_c;
          stb_d   = '0;
          ack_d   = 1'b1;
          state_d = RESP;
        end
`ifdef BUS_TIMEOUT_EN
        else if ((cnt_q + 8'd1) == 8'(TIMEOUT_CYCLES)) begin
          stb_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef BUS_TIMEOUT_EN
  assign o_wb_err = err_q;
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT_CYCLES;
  assign o_wb_err = 1'b0;
`endif

  assign o_wb_dat = rdat_q;
  assign o_wb_ack = ack_q;
  assign o_s_adr  = adr_q;
  assign o_s_dat  = wdat_q;
  assign o_s_sel  = sel_q;
  assign o_s_we   = we_q;
  assign o_s_stb  = stb_q;

endmodule
